// File: rtl/store_write_combiner.sv
// store_write_combiner
//
// Single-entry write-combining stage between the store buffer commit port
// and the D$ store port. Back-to-back committed stores to the same aligned
// XLEN word with the same WorldGuard ID are merged into one cache write. The
// stage also flags page-offset hazards to the load unit and drains on request
// for fences and AMOs.
//
// The core configuration is exposed as plain parameters (PLEN, XLEN,
// WG_ID_WIDTH), so the block stays self-contained.
//
// State table:
//   state    | meaning
//   IDLE     | no entry held; a new store can be accepted
//   HOLD     | entry held and open for merging; age counter running
//   ISSUE    | entry presented to the D$; waiting for out_gnt_i
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   in_req_i / in_gnt_o     committed store handshake
//   in_addr_i, in_data_i    store address and word-aligned data
//   in_be_i, in_wid_i       byte enables, WorldGuard ID
//   drain_i                 flush the held entry, block new accepts
//   page_offset_i           load page offset to check against the entry
//   page_offset_matches_o   held or issuing entry overlaps the load word
//   empty_o                 nothing held or issuing
//   out_req_o / out_gnt_i   D$ write handshake
//   out_addr_o ... out_wid_o  D$ write payload, straight from the entry regs

module store_write_combiner #(
  parameter int unsigned PLEN        = 56,
  parameter int unsigned XLEN        = 64,
  parameter int unsigned WG_ID_WIDTH = 4,
  parameter int unsigned TIMEOUT     = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_req_i,
  output logic                   in_gnt_o,
  input  logic [PLEN-1:0]        in_addr_i,
  input  logic [XLEN-1:0]        in_data_i,
  input  logic [XLEN/8-1:0]      in_be_i,
  input  logic [WG_ID_WIDTH-1:0] in_wid_i,
  input  logic                   drain_i,
  input  logic [11:0]            page_offset_i,
  output logic                   page_offset_matches_o,
  output logic                   empty_o,
  output logic                   out_req_o,
  input  logic                   out_gnt_i,
  output logic [PLEN-1:0]        out_addr_o,
  output logic [XLEN-1:0]        out_data_o,
  output logic [XLEN/8-1:0]      out_be_o,
  output logic [1:0]             out_size_o,
  output logic [WG_ID_WIDTH-1:0] out_wid_o
);

  localparam int unsigned BE_W  = XLEN / 8;
  localparam int unsigned OFF   = $clog2(BE_W);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0]       SIZE_FULL = 2'(OFF);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [PLEN-1:0]        addr_q;
  logic [XLEN-1:0]        data_q;
  logic [BE_W-1:0]        be_q;
  logic [WG_ID_WIDTH-1:0] wid_q;
  logic [CNT_W-1:0]       cnt_q;

  logic match;
  logic po_hit;
  logic force_issue;
  logic accept;

  assign match = in_req_i
              && (in_addr_i[PLEN-1:OFF] == addr_q[PLEN-1:OFF])
              && (in_wid_i == wid_q);

  assign po_hit = (page_offset_i[11:OFF] == addr_q[11:OFF]);

  // Any non-mergeable store also forces the entry out, so store order is
  // preserved: the refused store is taken in IDLE after the issue.
  assign force_issue = drain_i || (cnt_q == CNT_LAST) || po_hit
                    || (in_req_i && !match);

  always_comb begin
    state_d  = state_q;
    in_gnt_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_gnt_o = !drain_i;
        if (in_req_i && !drain_i) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        in_gnt_o = match && !force_issue;
        if (force_issue) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (out_gnt_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = in_req_i && in_gnt_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      wid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && accept) begin
        addr_q <= {in_addr_i[PLEN-1:OFF], {OFF{1'b0}}};
        data_q <= in_data_i;
        be_q   <= in_be_i;
        wid_q  <= in_wid_i;
        cnt_q  <= '0;
      end else if (state_q == ST_HOLD) begin
        // Age keeps running across merges so a steady stream of same-word
        // stores cannot hold the entry back indefinitely.
        cnt_q <= cnt_q + CNT_W'(1);
        if (accept) begin
          for (int i = 0; i < BE_W; i++) begin
            if (in_be_i[i]) data_q[8*i +: 8] <= in_data_i[8*i +: 8];
          end
          be_q <= be_q | in_be_i;
        end
      end
    end
  end

  // Size encoding: single byte, aligned half, aligned word, else full XLEN.
  // An empty mask (only possible after reset) reports size 0.
  logic is_half;
  logic is_word;

  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    for (int i = 0; i < BE_W / 2; i++) begin
      if (be_q == (BE_W'(2'b11) << (2 * i))) is_half = 1'b1;
    end
    for (int i = 0; i < BE_W / 4; i++) begin
      if (be_q == (BE_W'(4'b1111) << (4 * i))) is_word = 1'b1;
    end
  end

  always_comb begin
    out_size_o = SIZE_FULL;
    if (be_q == '0 || $onehot(be_q)) out_size_o = 2'd0;
    else if (is_half)                out_size_o = 2'd1;
    else if (is_word)                out_size_o = 2'd2;
  end

  assign out_req_o             = (state_q == ST_ISSUE);
  assign empty_o               = (state_q == ST_IDLE);
  assign page_offset_matches_o = (state_q != ST_IDLE) && po_hit;

  assign out_addr_o = addr_q;
  assign out_data_o = data_q;
  assign out_be_o   = be_q;
  assign out_wid_o  = wid_q;

  // Sub-word address bits play no role in word matching.
  logic unused_low_bits;
  assign unused_low_bits = ^{in_addr_i[OFF-1:0], page_offset_i[OFF-1:0]};

endmodule

// File: tb/tb_store_write_combiner.sv
module tb_store_write_combiner;

  localparam int PLEN = 56;
  localparam int XLEN = 64;
  localparam int WGW  = 4;
  localparam int TOUT = 8;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              in_req_i = 1'b0;
  logic              in_gnt_o;
  logic [PLEN-1:0]   in_addr_i = '0;
  logic [XLEN-1:0]   in_data_i = '0;
  logic [7:0]        in_be_i = '0;
  logic [WGW-1:0]    in_wid_i = '0;
  logic              drain_i = 1'b0;
  logic [11:0]       page_offset_i = 12'hFF8;
  logic              page_offset_matches_o;
  logic              empty_o;
  logic              out_req_o;
  logic              out_gnt_i = 1'b1;
  logic [PLEN-1:0]   out_addr_o;
  logic [XLEN-1:0]   out_data_o;
  logic [7:0]        out_be_o;
  logic [1:0]        out_size_o;
  logic [WGW-1:0]    out_wid_o;

  store_write_combiner #(
    .PLEN(PLEN), .XLEN(XLEN), .WG_ID_WIDTH(WGW), .TIMEOUT(TOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o),
    .in_addr_i(in_addr_i), .in_data_i(in_data_i), .in_be_i(in_be_i), .in_wid_i(in_wid_i),
    .drain_i(drain_i), .page_offset_i(page_offset_i),
    .page_offset_matches_o(page_offset_matches_o), .empty_o(empty_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i),
    .out_addr_o(out_addr_o), .out_data_o(out_data_o), .out_be_o(out_be_o),
    .out_size_o(out_size_o), .out_wid_o(out_wid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [7:0]      be;
    logic [1:0]      size;
    logic [WGW-1:0]  wid;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  failed = 0;
  int  cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [1:0] size_of(input logic [7:0] be);
    int n;
    int lo;
    logic [7:0] run;
    n  = $countones(be);
    lo = 0;
    if (n == 0) return 2'd0;
    while (!be[lo]) lo++;
    run = 8'((1 << n) - 1) << lo;
    if (be != run) return 2'd3;
    if (n == 1) return 2'd0;
    if (n == 2 && lo % 2 == 0) return 2'd1;
    if (n == 4 && lo % 4 == 0) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_d, input logic [7:0] be,
                                        input logic [63:0] new_d);
    logic [63:0] r;
    r = old_d;
    for (int i = 0; i < 8; i++) if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
    return r;
  endfunction

  task automatic push_exp(input logic [PLEN-1:0] a, input logic [63:0] d,
                          input logic [7:0] be, input logic [WGW-1:0] w);
    wr_t e;
    e.addr = a & ~PLEN'(7);
    e.data = d;
    e.be   = be;
    e.size = size_of(be);
    e.wid  = w;
    exp_q.push_back(e);
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input wr_t act, input wr_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got addr=%h data=%h be=%h size=%0d wid=%h expected addr=%h data=%h be=%h size=%0d wid=%h",
               name, act.addr, act.data, act.be, act.size, act.wid,
               exp.addr, exp.data, exp.be, exp.size, exp.wid);
    end
  endtask

  function automatic wr_t out_now();
    return {out_addr_o, out_data_o, out_be_o, out_size_o, out_wid_o};
  endfunction

  // Every D$ write cycle is compared against the head of the expected list;
  // the head retires only on the handshake, so a stall re-checks stability.
  always @(negedge clk_i) begin
    if (!rst_i && out_req_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_write: got addr=%h be=%h with no write expected", out_addr_o, out_be_o);
      end else begin
        check_w("dcache_write", out_now(), exp_q[0]);
        check("empty_in_issue", empty_o, 1'b0);
        if (out_gnt_i) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [PLEN-1:0] a, input logic [63:0] d,
                      input logic [7:0] be, input logic [WGW-1:0] w, output int gcyc);
    in_req_i = 1'b1; in_addr_i = a; in_data_i = d; in_be_i = be; in_wid_i = w;
    gcyc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (in_gnt_o) begin
        gcyc = cyc;
        step();
        break;
      end
      step();
    end
    in_req_i = 1'b0;
    if (gcyc < 0) begin
      tests++; failed++;
      $display("FAIL grant_timeout: got no grant for addr %h expected grant within 40 cycles", a);
    end
  endtask

  task automatic wait_req(input int budget, output int c);
    c = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (out_req_o) begin
        c = cyc;
        break;
      end
      step();
    end
    if (c < 0) begin
      tests++; failed++;
      $display("FAIL req_timeout: got out_req_o=0 expected 1 within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (empty_o && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      step();
    end
    check("drain_done", done, 1'b1);
    step();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int a, g, c;
    logic [63:0] d;
    wr_t snap;

    #2;
    check("rst_out_req", out_req_o, 1'b0);
    check("rst_empty", empty_o, 1'b1);
    check("rst_in_gnt", in_gnt_o, 1'b1);
    check("rst_po_match", page_offset_matches_o, 1'b0);
    check_w("rst_payload", out_now(), '0);
    step(); step();
    rst_i = 1'b0;

    // Single store: forced out by age only.
    push_exp(56'h8000_1004, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4'h1);
    send(56'h8000_1004, 64'h0000_0000_DEAD_BEEF, 8'h0F, 4'h1, a);
    check("single_hold_busy", empty_o, 1'b0);
    wait_req(20, c);
    check("single_latency", c - a, 9);
    check("single_addr", out_addr_o, 56'h8000_1000);
    check("single_be", out_be_o, 8'h0F);
    check("single_size", out_size_o, 2'd2);
    wait_idle(10);

    // Two halves of one word on consecutive cycles: one merged write.
    push_exp(56'h100, merge(64'h1111_1111_AABB_CCDD, 8'hF0, 64'h5566_7788_0000_0000), 8'hFF, 4'h5);
    send(56'h100, 64'h1111_1111_AABB_CCDD, 8'h0F, 4'h5, a);
    send(56'h104, 64'h5566_7788_0000_0000, 8'hF0, 4'h5, g);
    check("merge_second_gnt", g - a, 1);
    wait_req(20, c);
    check("merge_latency", c - a, 9);
    check("merge_data", out_data_o, 64'h5566_7788_AABB_CCDD);
    check("merge_be", out_be_o, 8'hFF);
    check("merge_size", out_size_o, 2'd3);
    wait_idle(10);

    // Different word: second store waits for the first write, order kept.
    push_exp(56'h100, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'h2);
    push_exp(56'h108, 64'hFEDC_BA98_7654_3210, 8'hFF, 4'h2);
    send(56'h100, 64'h0123_4567_89AB_CDEF, 8'hFF, 4'h2, a);
    send(56'h108, 64'hFEDC_BA98_7654_3210, 8'hFF, 4'h2, g);
    check("nomatch_refill_cycle", g - a, 3);
    wait_idle(20);

    // Same word, different wid: two writes, no merge; sizes 0 and 1.
    push_exp(56'h200, 64'h0000_0000_0000_0077, 8'h01, 4'h1);
    push_exp(56'h200, 64'h0000_0000_0099_0000, 8'h0C, 4'h2);
    send(56'h200, 64'h0000_0000_0000_0077, 8'h01, 4'h1, a);
    send(56'h200, 64'h0000_0000_0099_0000, 8'h0C, 4'h2, g);
    check("wid_refill_cycle", g - a, 3);
    wait_idle(20);

    // Page-offset hazard forces issue; D$ stalls for 5 cycles.
    push_exp(56'h2A0, 64'hCAFE_F00D_1234_5678, 8'hFF, 4'h3);
    send(56'h2A0, 64'hCAFE_F00D_1234_5678, 8'hFF, 4'h3, a);
    page_offset_i = 12'h2A4;
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    check("po_match_hold", page_offset_matches_o, 1'b1);
    check("po_not_yet_req", out_req_o, 1'b0);
    step();
    @(negedge clk_i);
    check("po_issue_next", out_req_o, 1'b1);
    check("po_match_issue", page_offset_matches_o, 1'b1);
    snap = out_now();
    for (int k = 0; k < 5; k++) begin
      step();
      @(negedge clk_i);
      check("stall_req_held", out_req_o, 1'b1);
      check_w("stall_payload_stable", out_now(), snap);
    end
    step();
    out_gnt_i = 1'b1;
    wait_idle(10);
    @(negedge clk_i);
    check("po_idle_no_match", page_offset_matches_o, 1'b0);
    step();
    page_offset_i = 12'hFF8;

    // Drain in HOLD: minimum latency of 2 cycles.
    push_exp(56'h400, 64'h0000_0000_0000_AB00, 8'h02, 4'h4);
    send(56'h400, 64'h0000_0000_0000_AB00, 8'h02, 4'h4, a);
    drain_i = 1'b1;
    wait_req(10, c);
    check("drain_latency", c - a, 2);
    step();
    // Drain in IDLE: nothing accepted.
    in_req_i = 1'b1; in_addr_i = 56'h500; in_data_i = 64'h1; in_be_i = 8'h01; in_wid_i = 4'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("drain_idle_no_gnt", in_gnt_o, 1'b0);
      check("drain_idle_empty", empty_o, 1'b1);
      step();
    end
    drain_i = 1'b0;
    push_exp(56'h500, 64'h1, 8'h01, 4'h0);
    g = cyc;
    send(56'h500, 64'h1, 8'h01, 4'h0, a);
    check("drain_release_gnt", a - g, 0);
    wait_idle(20);

    // Merge chain: age is not reset by merges, 9th store is refused.
    d = {8{8'h10}};
    for (int i = 1; i < 8; i++) d = merge(d, 8'(1 << i), {8{8'(8'h10 + i)}});
    push_exp(56'h300, d, 8'hFF, 4'h6);
    push_exp(56'h300, {8{8'hA0}}, 8'h01, 4'h6);
    send(56'h300, {8{8'h10}}, 8'h01, 4'h6, a);
    for (int i = 1; i < 8; i++) begin
      send(56'h300, {8{8'(8'h10 + i)}}, 8'(1 << i), 4'h6, g);
      check("chain_merge_gnt", g - a, i);
    end
    send(56'h300, {8{8'hA0}}, 8'h01, 4'h6, g);
    check("chain_ninth_gnt", g - a, 10);
    wait_idle(20);

    // Reset while issuing: write discarded immediately.
    push_exp(56'h600, 64'h0000_BEEF_0000_0000, 8'h30, 4'h7);
    send(56'h600, 64'h0000_BEEF_0000_0000, 8'h30, 4'h7, a);
    drain_i = 1'b1;
    out_gnt_i = 1'b0;
    wait_req(10, c);
    #1 rst_i = 1'b1;
    #1;
    check("rst_issue_req", out_req_o, 1'b0);
    check("rst_issue_empty", empty_o, 1'b1);
    exp_q.delete();
    drain_i = 1'b0;
    out_gnt_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_gnt", in_gnt_o, 1'b1);
    check_w("post_rst_payload", out_now(), '0);
    step();
    step();

    check("exp_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 ns");
    $fatal(1, "watchdog");
  end

endmodule
